// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_pkg
// Brief  : Shared constants, types and PC helpers for the RV32 fetch stage.
//          INST_NOP and RESET_PC are also consumed by decode/hazard logic.
// Rev    : 1.0  initial release
// ============================================================================
package inst_fetch_pkg;

  // ADDI x0,x0,0 -- canonical bubble instruction
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  // Default byte address fetched first after reset
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // One IF->ID slot: instruction word, its byte PC and whether it is real
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ivld;
  } if_slot_t;

  // What the fetch state does at the coming clock edge
  typedef enum logic [2:0] {
    ACT_ADV   = 3'd0,  // normal sequential advance
    ACT_START = 3'd1,  // first edge out of reset: enable the ROM only
    ACT_STALL = 3'd2,  // load-use stall: freeze and buffer current output
    ACT_JAL   = 3'd3,  // redirect from ID (PC-relative)
    ACT_EX    = 3'd4   // redirect from EX (absolute), highest priority
  } fetch_act_e;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  // JAL target: PC-relative, modulo 2^32, word aligned
  function automatic logic [31:0] jal_target(input logic [31:0] pc,
                                             input logic [31:0] offset);
    return word_align(pc + offset);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch
// Brief  : RV32 instruction fetch stage. Owns the PC, drives a synchronous
//          instruction ROM (1-cycle latency) and presents one instruction
//          plus its PC per cycle to ID. Holds the presented instruction
//          across load-use stalls and redirects on JAL (from ID) and taken
//          branches (from EX), emitting a NOP bubble for the squashed slot.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   imem_en      out  1        ROM read enable
//   imem_addr    out  IMEM_AW  ROM word address (pc[IMEM_AW+1:2])
//   imem_rdata   in   32       ROM data, valid one cycle after the address
//   inst         out  32       instruction to ID
//   inst_pc      out  32       byte PC of inst
//   inst_vld     out  1        1 = real instruction, 0 = bubble (NOP)
//   stall        in   1        load-use stall, repeat current outputs
//   ID_jmp_vld   in   1        JAL decoded from current inst
//   ID_jmp_addr  in   32       JAL byte offset relative to inst_pc
//   EX_jmp_vld   in   1        taken branch resolved in EX
//   EX_jmp_addr  in   32       absolute byte target of the branch
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC,
  parameter int unsigned IMEM_AW  = 10,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_vld,
  input  logic               stall,
  input  logic               ID_jmp_vld,
  input  logic [31:0]        ID_jmp_addr,
  input  logic               EX_jmp_vld,
  input  logic [31:0]        EX_jmp_addr
);

  logic [31:0] r_pc;        // next fetch PC
  logic [31:0] r_f2_pc;     // PC of the word arriving on imem_rdata
  logic        r_f2_vld;    // imem_rdata carries a real instruction
  logic        r_imem_en;
  logic        r_hold_vld;  // stall buffer occupied
  if_slot_t    r_hold;      // stall buffer contents (may be a bubble)

  if_slot_t    w_out;
  fetch_act_e  w_act;

  // --------------------------------------------------------------------------
  // Output mux: stall buffer, then live ROM data, then bubble
  // --------------------------------------------------------------------------
  always_comb begin
    w_out = '{inst: NOP_INST, pc: r_f2_pc, ivld: 1'b0};
    if (r_hold_vld) begin
      w_out = r_hold;
    end else if (r_f2_vld) begin
      w_out = '{inst: imem_rdata, pc: r_f2_pc, ivld: 1'b1};
    end
  end

  assign inst      = w_out.inst;
  assign inst_pc   = w_out.pc;
  assign inst_vld  = w_out.ivld;
  assign imem_en   = r_imem_en;
  // Upper PC bits are simply dropped, so fetches wrap modulo ROM depth
  assign imem_addr = r_pc[IMEM_AW+1:2];

  // --------------------------------------------------------------------------
  // Action select. EX beats stall and JAL; JAL only acts on a real,
  // non-stalled instruction.
  // --------------------------------------------------------------------------
  always_comb begin
    w_act = ACT_ADV;
    if (EX_jmp_vld) begin
      w_act = ACT_EX;
    end else if (stall) begin
      w_act = ACT_STALL;
    end else if (ID_jmp_vld && w_out.ivld) begin
      w_act = ACT_JAL;
    end else if (!r_imem_en) begin
      w_act = ACT_START;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_f2_pc    <= RESET_PC;
      r_f2_vld   <= 1'b0;
      r_imem_en  <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold     <= '{inst: NOP_INST, pc: RESET_PC, ivld: 1'b0};
    end else begin
      r_imem_en <= 1'b1;
      case (w_act)
        ACT_EX: begin
          // The word read at this edge belongs to the squashed path
          r_pc       <= word_align(EX_jmp_addr);
          r_f2_vld   <= 1'b0;
          r_hold_vld <= 1'b0;
        end
        ACT_STALL: begin
          // The ROM keeps reading r_pc, which overwrites imem_rdata with the
          // next word, so the presented slot must be captured here.
          if (!r_hold_vld) begin
            r_hold     <= w_out;
            r_hold_vld <= 1'b1;
          end
        end
        ACT_JAL: begin
          r_pc       <= jal_target(w_out.pc, ID_jmp_addr);
          r_f2_pc    <= w_out.pc + 32'd4;
          r_f2_vld   <= 1'b0;
          r_hold_vld <= 1'b0;
        end
        ACT_START: begin
          // ROM is only enabled from this edge, so nothing arrives yet
          r_f2_vld   <= 1'b0;
          r_hold_vld <= 1'b0;
        end
        default: begin
          r_f2_pc    <= r_pc;
          r_f2_vld   <= 1'b1;
          r_pc       <= r_pc + 32'd4;
          r_hold_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
